// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master slice.
// Holds the FSM state encoding, the SPI mode constant, default frame
// geometry and a helper for the divider counter width.
package spi_pkg;

  // Master FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  // SPI mode 0: CPOL=0 (sck idles low), CPHA=0 (sample on the rising edge).
  localparam int   SPI_MODE = 0;
  localparam logic SCK_IDLE = 1'b0;

  localparam int DEFAULT_CLK_DIV    = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // The divider needs to hold CLK_DIV-1; one spare bit keeps CLK_DIV=1 legal.
  function automatic int div_cnt_width(input int clk_div);
    return $clog2(clk_div) + 1;
  endfunction

endpackage

// File: rtl/spi_if.sv
// spi_if: word handshake plus SPI pin bundle between a user and spi_master.
// Ports: tx_data/tx_valid/tx_ready (word in), rx_data/rx_valid (word out),
//        ss_n/sck/mosi/miso (SPI pins). master = spi_master view, slave = user view.
interface spi_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  ss_n;
  logic                  sck;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, ss_n, sck, mosi
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, ss_n, sck, mosi
  );

endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick counter for the SPI master FSM.
// Ports: clk, resetn, load (restart a phase), en (count), tick (phase ends this cycle).
// load reloads CLK_DIV-1, so a phase entered on a load lasts exactly CLK_DIV cycles.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int            CW     = div_cnt_width(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick on the last cycle of the phase; the FSM changes state on that edge.
  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator, one word per ss_n assertion.
// Ports: clk, resetn, bus (spi_if.master: word handshake in, rx word out, SPI pins).
// Accept to tx_ready high takes (2*DATA_WIDTH+2)*CLK_DIV+1 cycles; tx_valid is
// ignored while busy. Every output comes straight from a flop.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LSB_FIRST  = 1
) (
  input  logic  clk,
  input  logic  resetn,
  spi_if.master bus
);

  localparam int                BCW      = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0]    LAST_BIT = BCW'(DATA_WIDTH - 1);

  spi_state_e            state_q,    state_d;
  logic                  ss_n_q,     ss_n_d;
  logic                  sck_q,      sck_d;
  logic                  mosi_q,     mosi_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [BCW-1:0]        bit_cnt_q,  bit_cnt_d;

  logic div_load;
  logic div_en;
  logic div_tick;

  // ---------------------------------------------------------------------------
  // Bit-order helpers: tx and rx use the same order so loopback is identity.
  // ---------------------------------------------------------------------------
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Drop the bit already on mosi; the next one moves into the output position.
  function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] w,
                                                      input logic                  b);
    return (LSB_FIRST != 0) ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  // ---------------------------------------------------------------------------
  // Phase timer: restarted on every state change, idle while waiting for work.
  // ---------------------------------------------------------------------------
  assign div_load = (state_d != state_q);
  assign div_en   = (state_q != ST_IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .resetn (resetn),
    .load   (div_load),
    .en     (div_en),
    .tick   (div_tick)
  );

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic. Pin updates are made on the edge
  // that enters a state, so each pin change lines up with the state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ss_n_d     = ss_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_shift_d = bus.tx_data;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          ss_n_d     = 1'b0;
          mosi_d     = first_bit(bus.tx_data);
          tx_ready_d = 1'b0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        // First bit has been on mosi for CLK_DIV cycles; raise sck and sample.
        if (div_tick) begin
          sck_d      = 1'b1;
          rx_shift_d = rx_insert(rx_shift_q, bus.miso);
          state_d    = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (div_tick) begin
          sck_d = SCK_IDLE;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            // mosi only moves on the falling edge, so the slave sees it settled.
            tx_shift_d = tx_advance(tx_shift_q);
            mosi_d     = first_bit(tx_advance(tx_shift_q));
            bit_cnt_d  = bit_cnt_q + BCW'(1);
            state_d    = ST_LOW;
          end
        end
      end

      ST_LOW: begin
        if (div_tick) begin
          sck_d      = 1'b1;
          rx_shift_d = rx_insert(rx_shift_q, bus.miso);
          state_d    = ST_HIGH;
        end
      end

      ST_HOLD: begin
        // Release ss_n and publish the word on the same edge.
        if (div_tick) begin
          ss_n_d     = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = ST_GAP;
        end
      end

      ST_GAP: begin
        // Guarantees ss_n stays high for at least CLK_DIV+1 cycles.
        if (div_tick) begin
          tx_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        ss_n_d     = 1'b1;
        sck_d      = SCK_IDLE;
        tx_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset aborts any frame in progress without an rx_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ss_n_q     <= 1'b1;
      sck_q      <= SCK_IDLE;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ss_n_q     <= ss_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign bus.ss_n     = ss_n_q;
  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with an rx scoreboard.
// Three DUTs: A = defaults (miso from loopback, slave model or tied 1),
// B = MSB first loopback, C = CLK_DIV=1 loopback.
module tb_spi_master;
  import spi_pkg::*;

  localparam int DW = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_if #(.DATA_WIDTH(DW)) if_a ();
  spi_if #(.DATA_WIDTH(DW)) if_b ();
  spi_if #(.DATA_WIDTH(DW)) if_c ();

  spi_master #(.CLK_DIV(4), .DATA_WIDTH(DW), .LSB_FIRST(1)) u_a (.clk(clk), .resetn(resetn), .bus(if_a));
  spi_master #(.CLK_DIV(4), .DATA_WIDTH(DW), .LSB_FIRST(0)) u_b (.clk(clk), .resetn(resetn), .bus(if_b));
  spi_master #(.CLK_DIV(1), .DATA_WIDTH(DW), .LSB_FIRST(1)) u_c (.clk(clk), .resetn(resetn), .bus(if_c));

  // Per-instance views: index 0 = A, 1 = B, 2 = C.
  logic          tx_valid_v [3];
  logic [DW-1:0] tx_data_v  [3];
  logic          txr_v [3];
  logic          rxv_v [3];
  logic          ssn_v [3];
  logic          sck_v [3];
  logic          mosi_v[3];
  logic [DW-1:0] rxd_v [3];

  int   miso_mode = 0;   // A only: 0 loopback, 1 slave model, 2 tied high
  logic slave_bit = 1'b0;

  assign if_a.tx_valid = tx_valid_v[0]; assign if_a.tx_data = tx_data_v[0];
  assign if_b.tx_valid = tx_valid_v[1]; assign if_b.tx_data = tx_data_v[1];
  assign if_c.tx_valid = tx_valid_v[2]; assign if_c.tx_data = tx_data_v[2];
  assign if_a.miso = (miso_mode == 0) ? if_a.mosi : ((miso_mode == 1) ? slave_bit : 1'b1);
  assign if_b.miso = if_b.mosi;
  assign if_c.miso = if_c.mosi;

  assign txr_v[0] = if_a.tx_ready; assign rxv_v[0] = if_a.rx_valid; assign ssn_v[0] = if_a.ss_n;
  assign sck_v[0] = if_a.sck;      assign mosi_v[0] = if_a.mosi;    assign rxd_v[0] = if_a.rx_data;
  assign txr_v[1] = if_b.tx_ready; assign rxv_v[1] = if_b.rx_valid; assign ssn_v[1] = if_b.ss_n;
  assign sck_v[1] = if_b.sck;      assign mosi_v[1] = if_b.mosi;    assign rxd_v[1] = if_b.rx_data;
  assign txr_v[2] = if_c.tx_ready; assign rxv_v[2] = if_c.rx_valid; assign ssn_v[2] = if_c.ss_n;
  assign sck_v[2] = if_c.sck;      assign mosi_v[2] = if_c.mosi;    assign rxd_v[2] = if_c.rx_data;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            inst;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // ---------------------------------------------------------------------------
  // Monitors, sampled on the falling clk edge
  // ---------------------------------------------------------------------------
  int            rise_cnt  [3];
  logic [DW-1:0] mosi_rec  [3];
  int            hi_run    [3];
  int            hi_len    [3];
  int            rx_cnt    [3];
  int            sck_bad   [3];
  logic          ssn_p     [3];
  logic          sck_p     [3];
  logic          rxv_p     [3];
  logic [DW-1:0] slv_pat = 8'hAA;
  int            slv_idx = 0;
  exp_t          e_pop;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!ssn_v[k] && ssn_p[k]) begin
        hi_len[k]   = hi_run[k];
        rise_cnt[k] = 0;
        mosi_rec[k] = '0;
      end
      if (sck_v[k] && !sck_p[k]) begin
        if (rise_cnt[k] < DW) mosi_rec[k][rise_cnt[k]] = mosi_v[k];
        rise_cnt[k]++;
        if (ssn_v[k]) sck_bad[k]++;
      end
      hi_run[k] = ssn_v[k] ? hi_run[k] + 1 : 0;
      if (rxv_p[k]) chk("rx_valid_single", rxv_v[k], 1'b0);
      if (rxv_v[k]) begin
        rx_cnt[k]++;
        chk("rx_valid_at_ss_rise", {ssn_p[k], ssn_v[k]}, 2'b01);
        chk("rx_valid_not_ready", txr_v[k], 1'b0);
        chk("rx_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e_pop = exp_q.pop_front();
          chk("rx_inst", k, e_pop.inst);
          chk("rx_data", rxd_v[k], e_pop.data);
        end
      end
    end
    // Slave model for A: bit 0 of the pattern at ss_n fall, next bit on each sck fall.
    if (!ssn_v[0] && ssn_p[0]) slv_idx = 0;
    else if (!sck_v[0] && sck_p[0] && slv_idx < DW - 1) slv_idx++;
    slave_bit = slv_pat[slv_idx];
    for (int k = 0; k < 3; k++) begin
      ssn_p[k] = ssn_v[k];
      sck_p[k] = sck_v[k];
      rxv_p[k] = rxv_v[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (always entered and left on a falling clk edge)
  // ---------------------------------------------------------------------------
  task automatic wait_ready(input int k, output int unsigned at);
    int n = 0;
    while (txr_v[k] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_in_time", txr_v[k], 1'b1);
    at = cyc;
  endtask

  task automatic send(input int k, input logic [DW-1:0] d, input bit push,
                      input logic [DW-1:0] exp, output int unsigned acc);
    int unsigned t;
    exp_t e;
    wait_ready(k, t);
    tx_data_v[k]  = d;
    tx_valid_v[k] = 1'b1;
    if (push) begin
      e.inst = k;
      e.data = exp;
      exp_q.push_back(e);
    end
    acc = cyc;
    @(negedge clk);
    tx_valid_v[k] = 1'b0;
    chk("ready_drops_after_accept", txr_v[k], 1'b0);
    tx_data_v[k] = ~d;
  endtask

  task automatic abort_after_rise3(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rise_cnt[k] < 3 && n < 200);
    chk("third_rise_seen", rise_cnt[k] >= 3, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_ss_n", ssn_v[k], 1'b1);
    chk("abort_sck", sck_v[k], 1'b0);
    chk("abort_ready", txr_v[k], 1'b1);
    chk("abort_rx_data", rxd_v[k], '0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int unsigned acc;
    int unsigned t;
    int          rx_before;
    for (int k = 0; k < 3; k++) begin
      tx_valid_v[k] = 1'b0;
      tx_data_v[k]  = '0;
      rise_cnt[k]   = 0;
      mosi_rec[k]   = '0;
      hi_run[k]     = 0;
      hi_len[k]     = 0;
      rx_cnt[k]     = 0;
      sck_bad[k]    = 0;
      ssn_p[k]      = 1'b1;
      sck_p[k]      = 1'b0;
      rxv_p[k]      = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ss_n",     ssn_v[0], 1'b1);
    chk("rst_sck",      sck_v[0], 1'b0);
    chk("rst_mosi",     mosi_v[0], 1'b0);
    chk("rst_ready",    txr_v[0], 1'b1);
    chk("rst_rx_valid", rxv_v[0], 1'b0);
    chk("rst_rx_data",  rxd_v[0], '0);
    chk("rst_b_ss_n",   ssn_v[1], 1'b1);
    chk("rst_c_ready",  txr_v[2], 1'b1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // A loopback 0xA5: data, edge count, bit order on mosi, frame timing
    send(0, 8'hA5, 1'b1, 8'hA5, acc);
    wait_ready(0, t);
    chk("a_frame_cycles", t - acc, 32'd73);
    chk("a_rises_a5", rise_cnt[0], 32'd8);
    chk("a_mosi_a5", mosi_rec[0], 8'hA5);
    chk("a_rx_hold_a5", rxd_v[0], 8'hA5);
    chk("a_rx_count", rx_cnt[0], 32'd1);

    // LSB first 0x01: mosi high only at the first rise
    send(0, 8'h01, 1'b1, 8'h01, acc);
    wait_ready(0, t);
    chk("a_mosi_01", mosi_rec[0], 8'h01);
    chk("a_rises_01", rise_cnt[0], 32'd8);

    // MSB first 0x01: mosi high only at the eighth rise
    send(1, 8'h01, 1'b1, 8'h01, acc);
    wait_ready(1, t);
    chk("b_frame_cycles", t - acc, 32'd73);
    chk("b_mosi_01", mosi_rec[1], 8'h80);
    chk("b_rises_01", rise_cnt[1], 32'd8);

    // Slave model returning 0xAA, then miso tied high
    miso_mode = 1;
    send(0, 8'h00, 1'b1, 8'hAA, acc);
    wait_ready(0, t);
    chk("a_slave_rx", rxd_v[0], 8'hAA);
    miso_mode = 2;
    send(0, 8'h3C, 1'b1, 8'hFF, acc);
    wait_ready(0, t);
    chk("a_tied_rx", rxd_v[0], 8'hFF);
    miso_mode = 0;

    // tx_valid held high: two frames, second data only taken at second accept
    wait_ready(0, t);
    rx_before = rx_cnt[0];
    tx_data_v[0]  = 8'h12;
    tx_valid_v[0] = 1'b1;
    exp_q.push_back('{inst: 0, data: 8'h12});
    exp_q.push_back('{inst: 0, data: 8'h34});
    @(negedge clk);
    chk("b2b_busy", txr_v[0], 1'b0);
    tx_data_v[0] = 8'h34;
    wait_ready(0, t);
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    chk("b2b_second_busy", txr_v[0], 1'b0);
    wait_ready(0, t);
    chk("b2b_gap_ge5", hi_len[0] >= 5, 1'b1);
    chk("b2b_rx_count", rx_cnt[0] - rx_before, 32'd2);

    // Reset after the third rise on A, then a clean frame
    send(0, 8'hC3, 1'b0, 8'h00, acc);
    rx_before = rx_cnt[0];
    abort_after_rise3(0);
    repeat (100) @(negedge clk);
    chk("a_no_rx_after_abort", rx_cnt[0], rx_before);
    send(0, 8'h5A, 1'b1, 8'h5A, acc);
    wait_ready(0, t);
    chk("a_rx_after_abort", rxd_v[0], 8'h5A);

    // Same on C with CLK_DIV=1
    send(2, 8'h3C, 1'b1, 8'h3C, acc);
    wait_ready(2, t);
    chk("c_frame_cycles", t - acc, 32'd19);
    chk("c_rises", rise_cnt[2], 32'd8);
    send(2, 8'h99, 1'b0, 8'h00, acc);
    rx_before = rx_cnt[2];
    abort_after_rise3(2);
    repeat (40) @(negedge clk);
    chk("c_no_rx_after_abort", rx_cnt[2], rx_before);
    send(2, 8'h5A, 1'b1, 8'h5A, acc);
    wait_ready(2, t);
    chk("c_rx_after_abort", rxd_v[2], 8'h5A);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("a_sck_outside_ss", sck_bad[0], 32'd0);
    chk("b_sck_outside_ss", sck_bad[1], 32'd0);
    chk("c_sck_outside_ss", sck_bad[2], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
